// File: rtl/thunderbird_pkg.sv
// Shared definitions for the Thunderbird tail-light sequencer:
// state codes, lamp patterns and the state-to-lamp decode.
package thunderbird_pkg;

  // State codes. Left chase steps, then right chase steps, then hazard.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_L1   = 3'd1;
  localparam logic [2:0] ST_L2   = 3'd2;
  localparam logic [2:0] ST_L3   = 3'd3;
  localparam logic [2:0] ST_R1   = 3'd4;
  localparam logic [2:0] ST_R2   = 3'd5;
  localparam logic [2:0] ST_R3   = 3'd6;
  localparam logic [2:0] ST_HAZ  = 3'd7;

  // Lamp patterns. Bit 0 is the innermost lamp; the chase fills outward.
  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_1   = 3'b001;
  localparam logic [2:0] LAMP_2   = 3'b011;
  localparam logic [2:0] LAMP_3   = 3'b111;

  // Lamp banks packed together for the decode helper.
  typedef struct packed {
    logic [2:0] left;
    logic [2:0] right;
  } lamps_t;

  // Moore decode: lamp banks depend on the state alone.
  // Any code not listed falls back to all lamps off.
  function automatic lamps_t decodeLamps(input logic [2:0] state);
    lamps_t lamps;
    lamps.left  = LAMP_OFF;
    lamps.right = LAMP_OFF;
    case (state)
      ST_L1:   lamps.left = LAMP_1;
      ST_L2:   lamps.left = LAMP_2;
      ST_L3:   lamps.left = LAMP_3;
      ST_R1:   lamps.right = LAMP_1;
      ST_R2:   lamps.right = LAMP_2;
      ST_R3:   lamps.right = LAMP_3;
      ST_HAZ: begin
        lamps.left  = LAMP_3;
        lamps.right = LAMP_3;
      end
      default: begin
        lamps.left  = LAMP_OFF;
        lamps.right = LAMP_OFF;
      end
    endcase
    return lamps;
  endfunction

endpackage

// File: rtl/thunderbird_lights.sv
// Thunderbird rear tail-light sequencer.
// A turn request runs a three-step outward chase on its bank.
// Both requests together flash all six lamps as hazards.
// Lamps decode from the state register only, so input glitches never reach the lamps.
module thunderbird_lights
  import thunderbird_pkg::*;
(
  output logic [2:0] L,
  output logic [2:0] R,
  input  logic       clock,
  input  logic       reset,
  input  logic       sign_left,
  input  logic       sign_right
);

  logic [2:0] r_state;
  logic [2:0] w_nextState;
  lamps_t     w_lamps;

  // State register; reset drops straight to IDLE and aborts any running chase.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: only IDLE looks at the stalk, so a started chase always runs to the end.
  always_comb begin
    w_nextState = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (sign_left && sign_right) begin
          w_nextState = ST_HAZ;
        end else if (sign_left) begin
          w_nextState = ST_L1;
        end else if (sign_right) begin
          w_nextState = ST_R1;
        end else begin
          w_nextState = ST_IDLE;
        end
      end
      ST_L1:   w_nextState = ST_L2;
      ST_L2:   w_nextState = ST_L3;
      ST_L3:   w_nextState = ST_IDLE;
      ST_R1:   w_nextState = ST_R2;
      ST_R2:   w_nextState = ST_R3;
      ST_R3:   w_nextState = ST_IDLE;
      ST_HAZ:  w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Lamp drive, a pure function of the current state.
  always_comb begin
    w_lamps = decodeLamps(r_state);
  end

  assign L = w_lamps.left;
  assign R = w_lamps.right;

endmodule

// File: tb/tb_thunderbird_lights.sv
// Self-checking bench for thunderbird_lights.
// Directed scenarios are followed by a randomized run.
// The randomized run is checked against a side/step model of the lights.
module tb_thunderbird_lights;

  logic [2:0] L;
  logic [2:0] R;
  logic       clock;
  logic       reset;
  logic       sign_left;
  logic       sign_right;

  int total = 0;
  int bad   = 0;

  // Reference model.
  // mSide is the bank currently lit: 0 = none, 1 = left, 2 = right, 3 = hazard.
  // mStep is how many lamps of that bank are lit.
  int mSide = 0;
  int mStep = 0;

  thunderbird_lights dut (
    .L         (L),
    .R         (R),
    .clock     (clock),
    .reset     (reset),
    .sign_left (sign_left),
    .sign_right(sign_right)
  );

  // 10 ns clock with rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model of the lights, written in terms of "which side, how far along".
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mSide = 0;
      mStep = 0;
    end else if (mSide == 0) begin
      if (sign_left && sign_right) begin
        mSide = 3;
        mStep = 3;
      end else if (sign_left) begin
        mSide = 1;
        mStep = 1;
      end else if (sign_right) begin
        mSide = 2;
        mStep = 1;
      end
    end else if (mSide == 3 || mStep == 3) begin
      mSide = 0;
      mStep = 0;
    end else begin
      mStep = mStep + 1;
    end
  end

  function automatic logic [2:0] modelLeft();
    if (mSide == 1 || mSide == 3) return 3'((1 << mStep) - 1);
    return 3'b000;
  endfunction

  function automatic logic [2:0] modelRight();
    if (mSide == 2 || mSide == 3) return 3'((1 << mStep) - 1);
    return 3'b000;
  endfunction

  // Advance to the next falling edge. Outputs are sampled there.
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic test_reset();
    logic [2:0] wantL [5];
    wantL = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b001};
    reset = 1'b0;
    sign_left = 1'b1;
    sign_right = 1'b0;
    #2 reset = 1'b1;
    #1;
    total++;
    if (L !== 3'b000 || R !== 3'b000) begin
      bad++;
      $display("[TB] FAIL reset_lamps got L=%b R=%b want L=000 R=000", L, R);
    end
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (L !== wantL[i] || R !== 3'b000) begin
        bad++;
        $display("[TB] FAIL left_chase[%0d] got L=%b R=%b want L=%b R=000", i, L, R, wantL[i]);
      end
    end
  endtask

  task automatic test_release_midway();
    logic [2:0] wantL [4];
    wantL = '{3'b111, 3'b000, 3'b000, 3'b000};
    tick();
    total++;
    if (L !== 3'b011) begin
      bad++;
      $display("[TB] FAIL midway_L2 got L=%b want L=011", L);
    end
    sign_left = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (L !== wantL[i] || R !== 3'b000) begin
        bad++;
        $display("[TB] FAIL release[%0d] got L=%b R=%b want L=%b R=000", i, L, R, wantL[i]);
      end
    end
  endtask

  task automatic test_right_hold();
    logic [2:0] wantR [4];
    wantR = '{3'b001, 3'b011, 3'b111, 3'b000};
    sign_right = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (R !== wantR[i % 4] || L !== 3'b000) begin
        bad++;
        $display("[TB] FAIL right_hold[%0d] got L=%b R=%b want L=000 R=%b", i, L, R, wantR[i % 4]);
      end
    end
    sign_right = 1'b0;
    tick();
  endtask

  task automatic test_hazard();
    logic [2:0] want [3];
    want = '{3'b111, 3'b000, 3'b111};
    sign_left = 1'b1;
    sign_right = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (L !== want[i] || R !== want[i]) begin
        bad++;
        $display("[TB] FAIL hazard[%0d] got L=%b R=%b want both %b", i, L, R, want[i]);
      end
    end
    sign_left = 1'b0;
    sign_right = 1'b0;
    tick();
    total++;
    if (L !== 3'b000 || R !== 3'b000) begin
      bad++;
      $display("[TB] FAIL hazard_off got L=%b R=%b want L=000 R=000", L, R);
    end
  endtask

  task automatic test_left_during_right();
    logic [2:0] wantL [7];
    logic [2:0] wantR [7];
    wantR = '{3'b011, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    wantL = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b011, 3'b111, 3'b000};
    sign_right = 1'b1;
    tick();
    total++;
    if (R !== 3'b001 || L !== 3'b000) begin
      bad++;
      $display("[TB] FAIL ldr_start got L=%b R=%b want L=000 R=001", L, R);
    end
    sign_right = 1'b0;
    sign_left = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 3) sign_left = 1'b0;
      total++;
      if (L !== wantL[i] || R !== wantR[i]) begin
        bad++;
        $display("[TB] FAIL ldr[%0d] got L=%b R=%b want L=%b R=%b", i, L, R, wantL[i], wantR[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [2:0] wantL [4];
    wantL = '{3'b001, 3'b011, 3'b111, 3'b000};
    sign_left = 1'b1;
    tick();
    tick();
    total++;
    if (L !== 3'b011) begin
      bad++;
      $display("[TB] FAIL areset_pre got L=%b want L=011", L);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (L !== 3'b000 || R !== 3'b000) begin
      bad++;
      $display("[TB] FAIL areset_now got L=%b R=%b want L=000 R=000", L, R);
    end
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) sign_left = 1'b0;
      total++;
      if (L !== wantL[i] || R !== 3'b000) begin
        bad++;
        $display("[TB] FAIL areset_after[%0d] got L=%b R=%b want L=%b R=000", i, L, R, wantL[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      total++;
      if (L !== modelLeft() || R !== modelRight()) begin
        bad++;
        $display("[TB] FAIL random[%0d] got L=%b R=%b want L=%b R=%b",
                 i, L, R, modelLeft(), modelRight());
      end
      sign_left  = ($urandom_range(0, 2) != 0);
      sign_right = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) begin
        #2 reset = 1'b1;
        #1;
        total++;
        if (L !== 3'b000 || R !== 3'b000) begin
          bad++;
          $display("[TB] FAIL random_reset[%0d] got L=%b R=%b want L=000 R=000", i, L, R);
        end
        #1 reset = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    sign_left = 1'b0;
    sign_right = 1'b0;
    test_reset();
    test_release_midway();
    test_right_hold();
    test_hazard();
    test_left_during_right();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
